// File: rtl/cordic_arbiter_pkg.sv
// Shared configuration for the cordic arbiter: word layout, requester count,
// credit depth and a constant-foldable clog2.
package cordic_arbiter_pkg;

    localparam int unsigned CA_NUM_REQ      = 4;
    localparam int unsigned CA_MAX_INFLIGHT = 16;
    localparam int unsigned CA_FIELD_WIDTH  = 16;
    localparam int unsigned CA_TOTAL_WIDTH  = 1 + 3 * CA_FIELD_WIDTH;

    // Field offsets inside one operation/result word
    localparam int unsigned CA_FUNC_BIT = 48;
    localparam int unsigned CA_X_LSB    = 32;
    localparam int unsigned CA_Y_LSB    = 16;
    localparam int unsigned CA_Z_LSB    = 0;

    typedef struct packed {
        logic        func;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } cordic_word_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order requester-ID FIFO; push and pop in the same cycle are both honoured,
// with the pushed entry bypassed to the head when the FIFO is empty.
module cordic_tag_fifo
    import cordic_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             full_c
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_c = (occ == '0);
        full_c  = (occ == OW'(DEPTH));
        do_push = push && (!full_c || pop);
        do_pop  = pop && (!empty_c || push);
        head_c  = empty_c ? push_data : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one cordic pipeline among NUM_REQ requesters,
// with credit-bounded issue and in-order routing of results back by tag.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = CA_NUM_REQ,
    parameter int unsigned ID_WIDTH     = clog2(NUM_REQ),
    parameter int unsigned TOTAL_WIDTH  = CA_TOTAL_WIDTH,
    parameter int unsigned MAX_INFLIGHT = CA_MAX_INFLIGHT,
    parameter int unsigned CNT_WIDTH    = clog2(MAX_INFLIGHT) + 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_rdy,
    output logic                           o_core_vld,
    output logic [TOTAL_WIDTH-1:0]         o_core_data,
    input  logic                           i_core_vld,
    input  logic [TOTAL_WIDTH-1:0]         i_core_data,
    output logic [NUM_REQ-1:0]             o_rsp_vld,
    output logic [ID_WIDTH-1:0]            o_rsp_id,
    output logic [TOTAL_WIDTH-1:0]         o_rsp_data,
    output logic                           o_idle,
    output logic                           o_err
);

    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [ID_WIDTH-1:0]  scan_id;
    logic [ID_WIDTH-1:0]  grant_id;
    logic [ID_WIDTH-1:0]  head_id;
    logic                 grant_vld;
    logic                 can_issue;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_WIDTH-1:0] inflight_q;
    logic [CNT_WIDTH-1:0] inflight_nxt;

    // Grant: first valid requester at or above the pointer, with wrap-around
    always_comb begin
        can_issue = i_en && (inflight_q < CNT_WIDTH'(MAX_INFLIGHT)) && !fifo_full;
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        o_req_rdy = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
            if (can_issue && !grant_vld && i_req_vld[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
        if (grant_vld) o_req_rdy[grant_id] = 1'b1;
    end

    // A result pops only when a tag exists (or is being pushed this cycle)
    always_comb begin
        pop          = i_core_vld && (!fifo_empty || grant_vld);
        inflight_nxt = inflight_q;
        if (grant_vld && !pop)      inflight_nxt = inflight_q + CNT_WIDTH'(1);
        else if (!grant_vld && pop) inflight_nxt = inflight_q - CNT_WIDTH'(1);
    end

    cordic_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ID_WIDTH)
    ) u_tag_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (grant_vld),
        .push_data (grant_id),
        .pop       (pop),
        .head_c    (head_id),
        .empty_c   (fifo_empty),
        .full_c    (fifo_full)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr      <= '0;
            inflight_q  <= '0;
            o_core_vld  <= 1'b0;
            o_core_data <= '0;
            o_rsp_vld   <= '0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
            o_idle      <= 1'b1;
            o_err       <= 1'b0;
        end else begin
            o_core_vld <= grant_vld;
            if (grant_vld) begin
                o_core_data <= i_req_data[32'(grant_id) * TOTAL_WIDTH +: TOTAL_WIDTH];
                rr_ptr      <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
            end
            o_rsp_vld <= pop ? (NUM_REQ'(1) << head_id) : '0;
            if (pop) begin
                o_rsp_id   <= head_id;
                o_rsp_data <= i_core_data;
            end
            if (i_core_vld && !pop) o_err <= 1'b1;
            inflight_q <= inflight_nxt;
            o_idle     <= (inflight_nxt == '0);
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency core model that
// returns each operation XORed with a constant mask.
module tb_cordic_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TW = 49;
    localparam logic [TW-1:0] MASK = 49'h0_1A82_5A82_2183;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_en;
    logic [NR-1:0]     i_req_vld;
    logic [NR*TW-1:0]  i_req_data;
    logic [NR-1:0]     o_req_rdy;
    logic              o_core_vld;
    logic [TW-1:0]     o_core_data;
    logic              i_core_vld;
    logic [TW-1:0]     i_core_data;
    logic [NR-1:0]     o_rsp_vld;
    logic [1:0]        o_rsp_id;
    logic [TW-1:0]     o_rsp_data;
    logic              o_idle;
    logic              o_err;

    logic              pipe_vld [32];
    logic [TW-1:0]     pipe_dat [32];
    logic              model_en;
    int                lat;
    logic              man_vld;
    logic [TW-1:0]     man_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_req_vld   (i_req_vld),
        .i_req_data  (i_req_data),
        .o_req_rdy   (o_req_rdy),
        .o_core_vld  (o_core_vld),
        .o_core_data (o_core_data),
        .i_core_vld  (i_core_vld),
        .i_core_data (i_core_data),
        .o_rsp_vld   (o_rsp_vld),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_data  (o_rsp_data),
        .o_idle      (o_idle),
        .o_err       (o_err)
    );

    // Core model: delay line, result = operation ^ MASK
    always @(posedge clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < 32; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_dat[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= o_core_vld;
            pipe_dat[0] <= o_core_data;
            for (int s = 1; s < 32; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_dat[s] <= pipe_dat[s-1];
            end
        end
    end

    assign i_core_vld  = model_en ? pipe_vld[lat-1] : man_vld;
    assign i_core_data = model_en ? (pipe_dat[lat-1] ^ MASK) : man_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk(input int g, input int k);
        return {1'(g & 1), 16'(g), 16'(k), 16'(16'hA5A5 ^ 16'(g * 7))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n   = 1'b0;
        i_en      = 1'b0;
        i_req_vld = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // All requesters valid for n grants; expects order 0,1,2,3,... and in-order responses
    task automatic run_rr(input int n, input int cnt_at, input string tag);
        int gi = 0;
        int ri = 0;
        for (int t = 0; t < n + 60 && ri < n; t++) begin
            if (gi < n) begin
                i_req_vld = '1;
                for (int k = 0; k < 4; k++) i_req_data[k*TW +: TW] = mk(gi, k);
            end else begin
                i_req_vld = '0;
            end
            #1;
            if (gi < n) begin
                chk({tag, "_grant"}, 64'(o_req_rdy), 64'(4'b0001 << (gi % 4)));
                gi++;
            end
            if (t == cnt_at) chk({tag, "_count"}, 64'(dut.inflight_q), 64'd5);
            tick();
            if (o_rsp_vld != '0) begin
                chk({tag, "_rsp_vld"}, 64'(o_rsp_vld), 64'(4'b0001 << (ri % 4)));
                chk({tag, "_rsp_id"}, 64'(o_rsp_id), 64'(ri % 4));
                chk({tag, "_rsp_data"}, 64'(o_rsp_data), 64'(mk(ri, ri % 4) ^ MASK));
                ri++;
            end
        end
        i_req_vld = '0;
        chk({tag, "_nresp"}, 64'(ri), 64'(n));
        chk({tag, "_idle"}, 64'(o_idle), 64'd1);
    endtask

    initial begin
        int n;
        int n_g, first_zero, pop_t, regrant, n_before, nr, ri;
        logic rdy_at_pop;

        model_en   = 1'b1;
        lat        = 6;
        man_vld    = 1'b0;
        man_data   = '0;
        i_req_data = '0;
        do_reset();

        // Reset state
        chk("rst_req_rdy", 64'(o_req_rdy), 64'd0);
        chk("rst_core_vld", 64'(o_core_vld), 64'd0);
        chk("rst_core_data", 64'(o_core_data), 64'd0);
        chk("rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
        chk("rst_rsp_id", 64'(o_rsp_id), 64'd0);
        chk("rst_idle", 64'(o_idle), 64'd1);
        chk("rst_err", 64'(o_err), 64'd0);

        // Single request from requester 2
        i_en = 1'b1;
        i_req_data[2*TW +: TW] = 49'h1_4000_0000_2183;
        i_req_vld = 4'b0100;
        #1;
        chk("t1_rdy", 64'(o_req_rdy), 64'b0100);
        tick();
        i_req_vld = '0;
        chk("t1_core_vld", 64'(o_core_vld), 64'd1);
        chk("t1_core_data", 64'(o_core_data), 64'h1_4000_0000_2183);
        chk("t1_busy", 64'(o_idle), 64'd0);
        n = 0;
        while (o_rsp_vld == '0 && n < 30) begin
            tick();
            n++;
        end
        chk("t1_latency", 64'(n), 64'd7);
        chk("t1_rsp_vld", 64'(o_rsp_vld), 64'b0100);
        chk("t1_rsp_id", 64'(o_rsp_id), 64'd2);
        chk("t1_rsp_data", 64'(o_rsp_data), 64'h1_5A82_5A82_0000);
        chk("t1_idle", 64'(o_idle), 64'd1);
        tick();
        chk("t1_rsp_drop", 64'(o_rsp_vld), 64'd0);
        chk("t1_rsp_hold", 64'(o_rsp_data), 64'h1_5A82_5A82_0000);
        chk("t1_core_drop", 64'(o_core_vld), 64'd0);

        // Round robin over 8 grants
        do_reset();
        i_en = 1'b1;
        run_rr(8, -1, "t2");

        // Credit limit with a 20-cycle core
        do_reset();
        lat = 20;
        i_en = 1'b1;
        i_req_data[0 +: TW] = mk(3, 0);
        n_g = 0; first_zero = -1; pop_t = -1; regrant = -1; n_before = 0; nr = 0;
        rdy_at_pop = 1'b1;
        for (int t = 0; t < 40; t++) begin
            i_req_vld = 4'b0001;
            #1;
            if (o_req_rdy[0]) begin
                n_g++;
                if (first_zero < 0) n_before++;
                else if (regrant < 0) regrant = t;
            end else if (first_zero < 0) begin
                first_zero = t;
            end
            if (i_core_vld && pop_t < 0) begin
                pop_t = t;
                rdy_at_pop = o_req_rdy[0];
            end
            tick();
            if (o_rsp_vld != '0) begin
                chk("t3_rsp_id", 64'(o_rsp_id), 64'd0);
                nr++;
            end
        end
        i_req_vld = '0;
        for (int t = 0; t < 80 && nr < n_g; t++) begin
            tick();
            if (o_rsp_vld != '0) nr++;
        end
        chk("t3_grants_before_stall", 64'(n_before), 64'd16);
        chk("t3_first_stall", 64'(first_zero), 64'd16);
        chk("t3_first_pop", 64'(pop_t), 64'd21);
        chk("t3_rdy_at_pop", 64'(rdy_at_pop), 64'd0);
        chk("t3_regrant", 64'(regrant), 64'd22);
        chk("t3_nresp", 64'(nr), 64'(n_g));
        chk("t3_idle", 64'(o_idle), 64'd1);

        // Steady grant+pop at count 5, 40 operations across FIFO wrap
        do_reset();
        lat = 4;
        i_en = 1'b1;
        run_rr(40, 10, "t4");

        // Grant enable dropped with 3 in flight
        do_reset();
        lat = 6;
        i_en = 1'b1;
        for (int k = 0; k < 4; k++) i_req_data[k*TW +: TW] = mk(0, k);
        i_req_vld = '1;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("t5_grant", 64'(o_req_rdy), 64'(4'b0001 << t));
            tick();
        end
        i_en = 1'b0;
        ri = 0;
        for (int t = 0; t < 30; t++) begin
            #1;
            if (o_req_rdy != '0) chk("t5_no_grant", 64'(o_req_rdy), 64'd0);
            tick();
            if (o_rsp_vld != '0) begin
                chk("t5_rsp_id", 64'(o_rsp_id), 64'(ri));
                chk("t5_rsp_data", 64'(o_rsp_data), 64'(mk(0, ri) ^ MASK));
                ri++;
            end
        end
        i_req_vld = '0;
        chk("t5_nresp", 64'(ri), 64'd3);
        chk("t5_idle", 64'(o_idle), 64'd1);

        // Spurious core result with empty FIFO
        model_en = 1'b0;
        man_data = 49'h0_1234_5678_9ABC;
        man_vld  = 1'b1;
        tick();
        man_vld = 1'b0;
        chk("t6_err_set", 64'(o_err), 64'd1);
        chk("t6_rsp_vld", 64'(o_rsp_vld), 64'd0);
        chk("t6_rsp_hold", 64'(o_rsp_data), 64'(mk(0, 2) ^ MASK));
        chk("t6_idle", 64'(o_idle), 64'd1);
        tick();
        tick();
        tick();
        chk("t6_err_sticky", 64'(o_err), 64'd1);
        do_reset();
        chk("t6_err_cleared", 64'(o_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one cordic pipeline among NUM_REQ independent requesters.
- Round-robin arbitration with per-requester valid/ready; issues at most one operation per cycle into the core.
- Records each issued requester ID in an in-order tag FIFO and routes every core result back to its originator.
- Sits between the requester blocks and the cordic instance; the core has no backpressure, so the arbiter bounds outstanding operations with a credit counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, requester ID width, equals clog2(NUM_REQ).
- TOTAL_WIDTH, 49, operation/result word: 1 function bit plus x, y, z at 16 bits each, matching the core.
- MAX_INFLIGHT, 16, credit limit and tag FIFO depth; must be >= core latency, power of two.
- CNT_WIDTH, 5, in-flight counter width, equals clog2(MAX_INFLIGHT)+1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_en  in  1  grant enable; 0 blocks new grants while in-flight operations drain.
- i_req_vld  in  NUM_REQ  per-requester request valid.
- i_req_data  in  NUM_REQ*TOTAL_WIDTH  per-requester operation; requester k occupies slice [k*TOTAL_WIDTH +: TOTAL_WIDTH].
- o_req_rdy  out  NUM_REQ  one-hot grant/accept (combinational).
- o_core_vld  out  1  issue valid to the core.
- o_core_data  out  TOTAL_WIDTH  operation to the core.
- i_core_vld  in  1  core result valid.
- i_core_data  in  TOTAL_WIDTH  core result.
- o_rsp_vld  out  NUM_REQ  one-hot response valid.
- o_rsp_id  out  ID_WIDTH  requester ID of the response.
- o_rsp_data  out  TOTAL_WIDTH  result word, shared by all requesters.
- o_idle  out  1  1 when the in-flight count is 0.
- o_err  out  1  sticky: core result arrived with the tag FIFO empty.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all outputs 0, except o_idle=1.
  - Tag FIFO emptied, in-flight count 0, round-robin pointer 0.
  - o_err cleared; reset is the only way to clear it.
- Grant conditions: a grant is made only when all of these hold: i_en=1, in-flight count < MAX_INFLIGHT, any i_req_vld bit set.
- Grant selection: the first requester with i_req_vld=1, searching from the pointer upward with wrap-around.
  - o_req_rdy[g]=1 in that cycle only; o_req_rdy is never asserted without the matching i_req_vld.
- Issue (on the grant edge):
  - o_core_vld<=1 and o_core_data<=i_req_data slice g, one cycle later.
  - g pushed into the tag FIFO; pointer <= (g+1) mod NUM_REQ.
- No grant: o_core_vld<=0, o_core_data holds its value, pointer unchanged.
- Response, i_core_vld=1 with FIFO non-empty:
  - Pop the head ID h.
  - Next cycle: o_rsp_vld<=one-hot(h), o_rsp_id<=h, o_rsp_data<=i_core_data.
  - Latency from core result to response is 1 cycle.
- Response, i_core_vld=1 with FIFO empty:
  - o_err<=1; no pop; o_rsp_vld<=0; count unchanged (no underflow).
- o_rsp_vld is 0 in every cycle not produced by a valid pop; o_rsp_id and o_rsp_data hold their values.
- In-flight count: +1 on grant, -1 on valid pop, unchanged when both occur in the same cycle.
  - At MAX_INFLIGHT with a pop in the same cycle, no grant is made that cycle; the freed credit is usable the next cycle.
- Tag FIFO: circular read/write pointers of clog2(MAX_INFLIGHT) bits.
  - Wrap-around is natural.
  - It cannot overflow, because count gates grants.
  - Push and pop in the same cycle are both honoured, including when the FIFO is empty at the start of the cycle.
- i_en deasserted mid-stream: no further grants; in-flight results still return and route normally; o_idle rises once count=0.
- Reset mid-operation: in-flight tags are discarded.
  - Results returning after reset hit an empty FIFO and set o_err.
  - The integrator must reset the core together with this block.
- Arbitration behaviour: the round-robin pointer advances only on a grant. Steady all-request load yields the grant order 0,1,2,3,0,… with no starvation.

Decomposition:
- Shared package/config include holds: TOTAL_WIDTH, the per-word field offsets (function bit, X, Y, Z), NUM_REQ, MAX_INFLIGHT, and a clog2 function.
- One sub-module: cordic_tag_fifo (synchronous, DEPTH/WIDTH parameters, push/pop/empty/full, simultaneous push+pop). Arbiter and credit logic stay in the top.

Test Plan:
- Single request: requester 2 requests with data 0x1_4000_0000_2183 → o_req_rdy=0b0100 that cycle; o_core_vld=1 with the same data next cycle.
  - The core model returns 0x1_5A82_5A82_0000 after 6 cycles → one cycle later o_rsp_vld=0b0100, o_rsp_id=2, o_rsp_data matches.
- All four requesting continuously for 8 grants → grant order 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Responses return in the same order with correct IDs; o_idle=1 after the last response.
- Credit limit: with MAX_INFLIGHT=16 and a core model of latency 20, requester 0 requests continuously.
  - Exactly 16 grants, then o_req_rdy=0 until the first result returns.
  - The next grant occurs the cycle after that pop.
- Simultaneous grant and pop at count 5 → count stays 5.
  - The FIFO head advances and the new ID is appended; order is preserved across pointer wrap after 40 operations.
- i_en=0 with 3 operations in flight and all requesters valid → no o_req_rdy; 3 responses delivered; o_idle=1.
- Spurious i_core_vld with the FIFO empty → o_err=1 and held; o_rsp_vld=0; a later reset clears o_err to 0.
